// File: rtl/fp32_add_arbiter.sv
// Round-robin front end sharing one fixed-latency fp32 adder among NUM_REQ requesters.
// Optional per-requester sticky exception flags: define FP32_ARB_STICKY_FLAGS_EN.
module fp32_add_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int ADD_LAT   = 5,
  parameter int RSP_DEPTH = 8
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [NUM_REQ-1:0]         req_valid_i,
  output logic [NUM_REQ-1:0]         req_ready_o,
  input  logic [32*NUM_REQ-1:0]      req_a_i,
  input  logic [32*NUM_REQ-1:0]      req_b_i,
  output logic                       add_valid_o,
  output logic [31:0]                add_a_o,
  output logic [31:0]                add_b_o,
  input  logic [31:0]                add_result_i,
  input  logic                       add_done_i,
  input  logic [2:0]                 add_flags_i,
  output logic                       rsp_valid_o,
  input  logic                       rsp_ready_i,
  output logic [$clog2(NUM_REQ)-1:0] rsp_id_o,
  output logic [31:0]                rsp_result_o,
  output logic [2:0]                 rsp_flags_o,
  output logic                       err_o,
  output logic [3*NUM_REQ-1:0]       sticky_flags_o,
  input  logic [NUM_REQ-1:0]         sticky_clr_i
);
  localparam int IDW = $clog2(NUM_REQ);
  localparam int CW  = $clog2(RSP_DEPTH) + 1;
  localparam int PW  = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;

  logic [IDW-1:0]             ptr;
  logic [NUM_REQ-1:0]         gnt;
  logic [IDW-1:0]             gnt_id;
  logic                       found, take;
  // stage 0 is the issue register, stage ADD_LAT lines up with add_done_i
  logic [ADD_LAT:0]           vld_pipe;
  logic [ADD_LAT:0][IDW-1:0]  id_pipe;
  logic [31:0]                iss_a, iss_b;
  logic [CW-1:0]              fifo_cnt, inflight, avail;
  logic [PW-1:0]              wr_ptr, rd_ptr;
  logic [IDW-1:0]             mem_id  [RSP_DEPTH];
  logic [31:0]                mem_res [RSP_DEPTH];
  logic [2:0]                 mem_flg [RSP_DEPTH];
  logic                       push, pop, mis, err_q;

  function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
    return (p == PW'(RSP_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    int idx;
    idx    = 0;
    gnt    = '0;
    gnt_id = '0;
    found  = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = (int'(ptr) + i) % NUM_REQ;
      if (!found && req_valid_i[idx]) begin
        found    = 1'b1;
        gnt[idx] = 1'b1;
        gnt_id   = IDW'(idx);
      end
    end
  end

  always_comb begin
    inflight = '0;
    for (int k = 0; k <= ADD_LAT; k++) inflight = inflight + CW'(vld_pipe[k]);
  end

  // every issued op already owns a FIFO slot, so the non-stallable adder can never overrun it
  assign avail       = CW'(RSP_DEPTH) - fifo_cnt - inflight;
  assign take        = found && (avail != '0);
  assign req_ready_o = (avail != '0) ? gnt : '0;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr      <= '0;
      vld_pipe <= '0;
      id_pipe  <= '0;
      iss_a    <= '0;
      iss_b    <= '0;
    end else begin
      vld_pipe <= {vld_pipe[ADD_LAT-1:0], take};
      id_pipe  <= {id_pipe[ADD_LAT-1:0], gnt_id};
      if (take) begin
        iss_a <= req_a_i[32*gnt_id +: 32];
        iss_b <= req_b_i[32*gnt_id +: 32];
        ptr   <= (gnt_id == IDW'(NUM_REQ - 1)) ? '0 : gnt_id + 1'b1;
      end
    end
  end

  assign add_valid_o = vld_pipe[0];
  assign add_a_o     = iss_a;
  assign add_b_o     = iss_b;

  assign push        = add_done_i & vld_pipe[ADD_LAT];
  assign mis         = add_done_i ^ vld_pipe[ADD_LAT];
  assign rsp_valid_o = (fifo_cnt != '0);
  assign pop         = rsp_valid_o & rsp_ready_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
      err_q    <= 1'b0;
    end else begin
      if (push) wr_ptr <= wrap_inc(wr_ptr);
      if (pop)  rd_ptr <= wrap_inc(rd_ptr);
      fifo_cnt <= fifo_cnt + CW'(push) - CW'(pop);
      if (mis) err_q <= 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_id[wr_ptr]  <= id_pipe[ADD_LAT];
      mem_res[wr_ptr] <= add_result_i;
      mem_flg[wr_ptr] <= add_flags_i;
    end
  end

  assign rsp_id_o     = rsp_valid_o ? mem_id[rd_ptr]  : '0;
  assign rsp_result_o = rsp_valid_o ? mem_res[rd_ptr] : '0;
  assign rsp_flags_o  = rsp_valid_o ? mem_flg[rd_ptr] : '0;
  assign err_o        = err_q;

  a_no_fifo_ovf: assert property (@(posedge clk_i) disable iff (rst_i)
    !(push && !pop && fifo_cnt == CW'(RSP_DEPTH)));

`ifdef FP32_ARB_STICKY_FLAGS_EN
  logic [3*NUM_REQ-1:0] sticky_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sticky_q <= '0;
    end else begin
      for (int k = 0; k < NUM_REQ; k++) begin
        if (sticky_clr_i[k])
          sticky_q[3*k +: 3] <= 3'b000;
        else if (pop && rsp_id_o == IDW'(k))
          sticky_q[3*k +: 3] <= sticky_q[3*k +: 3] | rsp_flags_o;
      end
    end
  end

  assign sticky_flags_o = sticky_q;
`else
  logic unused_clr;
  assign unused_clr     = ^sticky_clr_i;
  assign sticky_flags_o = '0;
`endif

endmodule

// File: tb/tb_fp32_add_arbiter.sv
// Directed bench for fp32_add_arbiter; a fixed-latency stand-in models the external adder.
module tb_fp32_add_arbiter;
  localparam int NR  = 4;
  localparam int LAT = 5;
  localparam int DEP = 8;

  logic              clk_i = 1'b0;
  logic              rst_i;
  logic [NR-1:0]     req_valid_i, req_ready_o;
  logic [32*NR-1:0]  req_a_i, req_b_i;
  logic              add_valid_o, add_done_i;
  logic [31:0]       add_a_o, add_b_o, add_result_i;
  logic [2:0]        add_flags_i;
  logic              rsp_valid_o, rsp_ready_i;
  logic [1:0]        rsp_id_o;
  logic [31:0]       rsp_result_o;
  logic [2:0]        rsp_flags_o;
  logic              err_o;
  logic [3*NR-1:0]   sticky_flags_o;
  logic [NR-1:0]     sticky_clr_i;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk_i = ~clk_i;

  fp32_add_arbiter #(.NUM_REQ(NR), .ADD_LAT(LAT), .RSP_DEPTH(DEP)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_a_i(req_a_i), .req_b_i(req_b_i),
    .add_valid_o(add_valid_o), .add_a_o(add_a_o), .add_b_o(add_b_o),
    .add_result_i(add_result_i), .add_done_i(add_done_i), .add_flags_i(add_flags_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_id_o(rsp_id_o),
    .rsp_result_o(rsp_result_o), .rsp_flags_o(rsp_flags_o),
    .err_o(err_o), .sticky_flags_o(sticky_flags_o), .sticky_clr_i(sticky_clr_i)
  );

  // adder stand-in: two known fp32 cases, otherwise a^b so results identify their operands
  function automatic logic [31:0] stub_res(input logic [31:0] a, input logic [31:0] b);
    if (a == 32'h3F80_0000 && b == 32'h4000_0000) return 32'h4040_0000;
    if (a == 32'h7F80_0000 && b == 32'hFF80_0000) return 32'h7FC0_0000;
    return a ^ b;
  endfunction

  function automatic logic [2:0] stub_flg(input logic [31:0] a, input logic [31:0] b);
    return (a == 32'h7F80_0000 && b == 32'hFF80_0000) ? 3'b001 : 3'b000;
  endfunction

  logic [LAT-1:0] st_v;
  logic [31:0]    st_a [LAT];
  logic [31:0]    st_b [LAT];
  logic           force_done;

  always @(posedge clk_i) begin
    if (rst_i) st_v <= '0;
    else       st_v <= {st_v[LAT-2:0], add_valid_o};
    st_a[0] <= add_a_o;
    st_b[0] <= add_b_o;
    for (int k = 1; k < LAT; k++) begin
      st_a[k] <= st_a[k-1];
      st_b[k] <= st_b[k-1];
    end
  end

  assign add_done_i   = st_v[LAT-1] | force_done;
  assign add_result_i = stub_res(st_a[LAT-1], st_b[LAT-1]);
  assign add_flags_i  = stub_flg(st_a[LAT-1], st_b[LAT-1]);

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #2;
  endtask

  task automatic smp();
    @(negedge clk_i);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_ready"}, req_ready_o, '0);
    chk({tag, "_addv"},  add_valid_o, 0);
    chk({tag, "_adda"},  add_a_o, 0);
    chk({tag, "_addb"},  add_b_o, 0);
    chk({tag, "_rspv"},  rsp_valid_o, 0);
    chk({tag, "_rspd"},  {rsp_id_o, rsp_flags_o, rsp_result_o[26:0]}, 0);
    chk({tag, "_err"},   err_o, 0);
    chk({tag, "_stky"},  sticky_flags_o, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int first, ri, ng, np, bad;
    logic got;
    rst_i = 1'b1; req_valid_i = '0; req_a_i = '0; req_b_i = '0;
    rsp_ready_i = 1'b0; sticky_clr_i = '0; force_done = 1'b0;
    step(); step(); smp();
    chk_reset_vals("rst0");
    step(); rst_i = 1'b0;

    // single request from requester 2: 1.0 + 2.0
    req_a_i[64 +: 32] = 32'h3F80_0000;
    req_b_i[64 +: 32] = 32'h4000_0000;
    req_valid_i = 4'b0100;
    smp(); chk("single_gnt", req_ready_o, 4'b0100);
    step(); req_valid_i = '0; first = 0;
    for (int k = 1; k <= 12; k++) begin
      smp();
      if (k == 1) begin
        chk("single_issue", add_valid_o, 1);
        chk("single_a", add_a_o, 32'h3F80_0000);
        chk("single_b", add_b_o, 32'h4000_0000);
      end
      if (k == 2) chk("single_pulse", add_valid_o, 0);
      if (rsp_valid_o && first == 0) first = k;
      if (k < 12) step();
    end
    chk("single_lat", first, 7);
    chk("single_id", rsp_id_o, 2);
    chk("single_res", rsp_result_o, 32'h4040_0000);
    chk("single_flg", rsp_flags_o, 3'b000);
    step(); rsp_ready_i = 1'b1; smp();
    step(); rsp_ready_i = 1'b0; smp();
    chk("single_pop", rsp_valid_o, 0);

    // round robin from ptr=0, all requesters valid, consumer always ready
    step(); rst_i = 1'b1; step(); step(); rst_i = 1'b0;
    for (int k = 0; k < NR; k++) begin
      req_a_i[32*k +: 32] = 32'h100 + k;
      req_b_i[32*k +: 32] = 32'h0;
    end
    rsp_ready_i = 1'b1; req_valid_i = 4'hF; ri = 0;
    for (int c = 0; c < 40; c++) begin
      smp();
      if (c < 8) begin
        chk("rr_gnt", req_ready_o, 4'b0001 << (c % 4));
        if (c > 0) chk("rr_issue", add_valid_o, 1);
      end
      if (rsp_valid_o && ri < 8) begin
        chk("rr_id", rsp_id_o, ri % 4);
        chk("rr_res", rsp_result_o, 32'h100 + (ri % 4));
        ri++;
      end
      step();
      if (c == 7) req_valid_i = '0;
    end
    chk("rr_count", ri, 8);

    // backpressure: credits bound grants to the FIFO depth
    rsp_ready_i = 1'b0; req_valid_i = 4'hF; ng = 0;
    for (int c = 0; c < 20; c++) begin
      smp();
      if (|(req_ready_o & req_valid_i)) ng++;
      step();
    end
    chk("bp_grants", ng, 8);
    smp(); chk("bp_blocked", req_ready_o, '0);
    step(); rsp_ready_i = 1'b1; smp();
    step(); rsp_ready_i = 1'b0; ng = 0;
    for (int c = 0; c < 10; c++) begin
      smp();
      if (|(req_ready_o & req_valid_i)) ng++;
      step();
    end
    chk("bp_one_more", ng, 1);
    req_valid_i = '0; rsp_ready_i = 1'b1; np = 0;
    for (int c = 0; c < 30; c++) begin
      smp();
      if (rsp_valid_o) np++;
      step();
    end
    chk("bp_drain", np, 8);
    rsp_ready_i = 1'b0;

    // inf + -inf from requester 1 gives qNaN with invalid flag
    req_a_i[32 +: 32] = 32'h7F80_0000;
    req_b_i[32 +: 32] = 32'hFF80_0000;
    req_valid_i = 4'b0010;
    smp(); chk("inv_gnt", req_ready_o, 4'b0010);
    step(); req_valid_i = '0; got = 1'b0;
    for (int c = 0; c < 15 && !got; c++) begin
      smp();
      if (rsp_valid_o) got = 1'b1;
      else step();
    end
    chk("inv_seen", got, 1);
    chk("inv_id", rsp_id_o, 1);
    chk("inv_res", rsp_result_o, 32'h7FC0_0000);
    chk("inv_flg", rsp_flags_o, 3'b001);
    step(); rsp_ready_i = 1'b1; smp();
    step(); rsp_ready_i = 1'b0; smp();
`ifdef FP32_ARB_STICKY_FLAGS_EN
    chk("stky_set", sticky_flags_o, 12'h008);
    step(); sticky_clr_i = 4'b0010; smp();
    step(); sticky_clr_i = '0; smp();
    chk("stky_clr", sticky_flags_o, 12'h000);
`else
    chk("stky_off", sticky_flags_o, 12'h000);
`endif

    // spurious done with nothing in flight
    step(); force_done = 1'b1; smp();
    step(); force_done = 1'b0; smp();
    chk("err_set", err_o, 1);
    chk("err_nopush", rsp_valid_o, 0);
    step(); smp(); step(); smp(); step(); smp();
    chk("err_hold", err_o, 1);

    // reset with three operations in flight
    step(); req_valid_i = 4'b0111; smp();
    step(); smp();
    step(); smp();
    step(); req_valid_i = '0; rst_i = 1'b1;
    smp(); chk("mid_inflight", add_valid_o, 1);
    step(); smp();
    chk_reset_vals("rst_mid");
    step(); rst_i = 1'b0; bad = 0;
    for (int c = 0; c < 15; c++) begin
      smp();
      if (rsp_valid_o || err_o) bad++;
      step();
    end
    chk("post_rst_quiet", bad, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/fp32_add_arbiter.md
# fp32_add_arbiter

Round-robin arbiter and scheduler that shares one pipelined `fp32Adder` among `NUM_REQ` requesters. It accepts operand pairs over per-requester valid/ready channels and issues at most one operation per cycle into the adder. It tracks each in-flight operation's requester ID in a shift register that mirrors the adder's fixed latency. Completed results are buffered in a credit-protected response FIFO, so a stalled consumer never loses a result from the non-stallable adder.

## Interface
- `NUM_REQ`, 4: requester count, 2..8.
- `ADD_LAT`, 5: adder latency in cycles, from `add_valid_o` sampled to `add_done_i` high.
- `RSP_DEPTH`, 8: response FIFO entries; must be ≥ 1, power of two.
- `clk_i` in 1: single clock, rising edge.
- `rst_i` in 1: reset, synchronous, active-high.
- `req_valid_i` in `NUM_REQ`: per-requester operation request.
- `req_ready_o` out `NUM_REQ`: one-hot grant; a transfer occurs where valid & ready.
- `req_a_i`, `req_b_i` in `32*NUM_REQ`: operands; requester k uses slice [32k+31:32k].
- `add_valid_o` out 1: issue strobe to adder `valid_i`.
- `add_a_o`, `add_b_o` out 32: operands to adder `A`/`B`.
- `add_result_i` in 32: adder `result_o`.
- `add_done_i` in 1: adder `done_o`.
- `add_flags_i` in 3: {overflow, underflow, invalid} from adder.
- `rsp_valid_o` out 1: response available.
- `rsp_ready_i` in 1: consumer accepts response.
- `rsp_id_o` out `$clog2(NUM_REQ)`: requester that owns the response.
- `rsp_result_o` out 32, `rsp_flags_o` out 3: result and {ovf, unf, inv}.
- `err_o` out 1: sticky protocol error (done/tag mismatch).
- `sticky_flags_o` out `3*NUM_REQ`: per-requester accumulated exception flags (macro-dependent).
- `sticky_clr_i` in `NUM_REQ`: per-requester clear of sticky flags.

## Operation
- Credits: `avail = RSP_DEPTH − fifo_count − inflight`, where `inflight` counts the issue register plus all tag-shift-register entries with valid set. A grant is allowed only when `avail > 0`.
- Arbitration: round-robin. The search starts at `ptr`. Grant goes to the first index with valid set. `req_ready_o` is combinational from `req_valid_i`, `ptr` and `avail`, and is all-zero when `avail == 0`. On a grant, `ptr` advances to granted index + 1, with wrap from `NUM_REQ−1` to 0.
- Issue register: on a grant, latch operands and ID. `add_valid_o` is high for exactly one cycle per grant, and operands hold their value when idle.
- Tag shift register: `ADD_LAT` stages of {valid, id}. It shifts every cycle and is loaded from the issue register.
- Completion: in the cycle `add_done_i` is high, the last stage must have valid set.
  - On a match, push {id, result, flags} into the FIFO.
  - `add_done_i` with an empty last stage, or a valid last stage without `add_done_i`: set `err_o` and drop the result or tag. `err_o` clears only on reset.
- FIFO: first-word-fall-through from registered storage. It pops when `rsp_valid_o & rsp_ready_i`. Simultaneous push and pop keeps the count unchanged.
- Credit accounting in one cycle: a grant consumes 1 credit; a pop returns 1 credit. Both together leave `avail` unchanged. Overflow is impossible by construction; an assertion checks for it.
- Arithmetic: counts are `$clog2(RSP_DEPTH)+1` bits, with no wrap. FIFO pointers wrap modulo `RSP_DEPTH`.

## Timing
- Values after reset:
  - Low: `req_ready_o` (when `req_valid_i` is low), `add_valid_o`, `rsp_valid_o`, `err_o`, `sticky_flags_o`.
  - Zero: `add_a_o`, `add_b_o`, `rsp_*` data.
  - `ptr` = 0, FIFO empty, tag register cleared.
- Grant at cycle T gives `add_valid_o` at T+1 and `add_done_i` at T+1+`ADD_LAT`.
- The FIFO push takes effect at that same edge, so `rsp_valid_o` is high at T+2+`ADD_LAT` (7 cycles with the default) if the FIFO was empty.
- Throughput is 1 grant per cycle while credits last. With `rsp_ready_i` tied high, sustained throughput is 1 per cycle when `RSP_DEPTH ≥ ADD_LAT+2`.
- Reset mid-operation: all in-flight tags and FIFO contents are discarded. The adder must be reset in the same sequence. Results arriving after reset hit an empty tag stage and set `err_o`.

## Configuration
- `FP32_ARB_STICKY_FLAGS_EN` defined:
  - On each FIFO pop, OR `rsp_flags_o` into `sticky_flags_o[3*id+:3]`.
  - `sticky_clr_i[k]` zeroes entry k. Clear wins over a same-cycle set for the same k.
- Not defined: `sticky_flags_o` is constant 0, `sticky_clr_i` is ignored, and no sticky storage is built.

## Test plan
- Single request, requester 2, A=0x3F800000 and B=0x40000000 → `rsp_valid_o` 7 cycles after grant, `rsp_id_o`=2, result 0x40400000, flags 000.
- All 4 requesters valid continuously, `rsp_ready_i`=1 → grant order 0,1,2,3,0…, one `add_valid_o` per cycle, responses in the same ID order.
- `rsp_ready_i`=0, all requesting → exactly 8 grants, then `req_ready_o`=0. Raising `rsp_ready_i` for 1 cycle → exactly one new grant.
- A=0x7F800000, B=0xFF800000 from requester 1 → result 0x7FC00000, `rsp_flags_o`=001. With the macro defined, `sticky_flags_o[5:3]`=001 until `sticky_clr_i[1]` pulses.
- Force `add_done_i` high with no in-flight tag → `err_o` high the next cycle and held; FIFO count unchanged.
- Assert `rst_i` with 3 operations in flight → all outputs at reset values the next cycle, then `rsp_valid_o` stays low after reset releases.
